// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit (master)
// and the instruction memory (slave).
interface pc_fetch_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer: one instruction per FETCH/WAIT/EXEC window,
// next-PC select and sticky misaligned-target trap.
module pc_fetch_unit #(
    parameter int unsigned    XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    input  logic [XLEN-1:0] ALUResult,
    input  logic            StallF,
    pc_fetch_unit_if.master imem,
    output logic [31:0]     InstrF,
    output logic            InstrValidF,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] PCPlus4F,
    output logic            misalign_trap,
    output logic [XLEN-1:0] trap_pc
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_EXEC  = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    state_t          state;
    logic            trap_q;
    logic [XLEN-1:0] next_pc;

    assign PCPlus4F = PCF + XLEN'(4);

    // JALR (bit1) wins over bit0; its target has bit0 forced low before the alignment check.
    always_comb begin
        next_pc = PCPlus4F;
        if (PCSrc[1])
            next_pc = ALUResult & ~XLEN'(1);
        else if (PCSrc[0])
            next_pc = PCTarget;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            PCF     <= RESET_PC;
            InstrF  <= '0;
            trap_q  <= 1'b0;
            trap_pc <= '0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (imem.imem_req_ready)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem.imem_rsp_valid) begin
                        InstrF <= imem.imem_rsp_data;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!StallF) begin
                        if (next_pc[1:0] == 2'b00) begin
                            PCF   <= next_pc;
                            state <= S_FETCH;
                        end else begin
                            trap_q  <= 1'b1;
                            trap_pc <= next_pc;
                            state   <= S_TRAP;
                        end
                    end
                end
                S_TRAP: begin
                    state <= S_TRAP;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    // Gated by reset so these read 0 for the whole time reset is held, not only after its first edge.
    assign imem.imem_req_valid = (state == S_FETCH) && !reset;
    assign imem.imem_addr      = PCF;
    assign InstrValidF         = (state == S_EXEC) && !reset;
    assign misalign_trap       = trap_q && !reset;

endmodule
